branch_redirect_ctrl: RTL and testbench
=======================================

# branch_redirect_ctrl

Sequences control flow around the EX-stage branch-decision unit in the pipelined RV32I core. It predicts conditional-branch direction in ID from a 2-bit-counter history table and redirects fetch on predicted-taken branches. It checks each EX-resolved `Decision` against the carried prediction, and on a mispredict drives a registered PC redirect plus pipeline flushes. It also maintains branch and mispredict counters.

## Interface
- `XLEN`, 32, datapath/PC width
- `BHT_ENTRIES`, 16, history-table entries (power of two, ≥2)
- `IDX_W`, $clog2(BHT_ENTRIES), table index width (derived)

- `clk`  in  1  core clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `stall`  in  1  pipeline hold (hazard unit); freezes resolution and table updates
- `id_valid`, `id_is_branch`  in  1 each  ID holds a valid conditional branch
- `id_pc`, `id_target`  in  XLEN each  ID branch PC and PC+imm
- `id_pred_taken`  out  1  prediction, carried down the pipe to EX
- `ex_valid`, `ex_is_branch`  in  1 each  EX holds a valid conditional branch
- `ex_decision`  in  1  resolved outcome from the branch-decision unit
- `ex_pred_taken`  in  1  prediction carried with the branch
- `ex_pc`, `ex_target`  in  XLEN each  branch PC and taken target
- `pc_redirect`  out  1  fetch must load `pc_redirect_target` next edge
- `pc_redirect_target`  out  XLEN  redirect address
- `flush_if_id`, `flush_id_ex`, `flush_ex_mem`  out  1 each  clear the named pipeline register next edge
- `br_count`, `mispred_count`  out  32 each  performance counters

## Operation
- States: RUN, RECOVER. Reset → RUN.
- Resolution is accepted when `ex_valid & ex_is_branch & !stall & state==RUN`.
- Mispredict is an accepted resolution with `ex_decision != ex_pred_taken`.
- RUN → RECOVER on mispredict. RECOVER → RUN unconditionally after one cycle, ignoring `stall`.
- On a mispredict, register the correct PC: `ex_target` if `ex_decision`, else `ex_pc + 4` (mod 2^XLEN).
- In RECOVER:
  - assert `pc_redirect` with the registered PC, plus all three flushes;
  - ignore EX inputs, since they are wrong-path;
  - force `id_pred_taken = 0`.
- ID redirect, combinational, in RUN only: when `id_valid & id_is_branch & id_pred_taken & !stall`, assert `pc_redirect` with `pc_redirect_target = id_target`, and assert `flush_if_id` only.
- Priority: RECOVER redirect over ID redirect.
- Idle outputs: `pc_redirect = 0`, flushes 0, `pc_redirect_target = 0`.
- History table:
  - index `pc[IDX_W+1:2]`, 2-bit saturating counters, predict taken when MSB = 1;
  - on accepted resolution, increment if taken, decrement if not taken, saturating at 0 and 3;
  - an ID read of the index being written in the same cycle returns the old value.
- Counters: `br_count` +1 per accepted resolution; `mispred_count` +1 per mispredict; both wrap at 2^32.
- JAL/JALR are outside this block's scope; the `ex_is_branch`/`id_is_branch` inputs must be 0 for them.

## Timing
- Reset (async assert, sync deassert handled upstream):
  - state RUN, all table entries `2'b01` (weakly not-taken), counters 0;
  - registered redirect PC 0, all outputs 0.
- `id_pred_taken` and the ID redirect are combinational from `id_pc` and table state, with zero latency.
- Mispredict latency: EX resolution in cycle t; `pc_redirect` and flushes high in cycle t+1 for exactly one cycle; fetch from the correct PC in cycle t+2.
- Back-to-back: a branch in EX during RECOVER is discarded (no update, no count).
- `stall` during RUN: no update, no count, no ID redirect. It does not extend RECOVER.
- Reset mid-RECOVER drops the pending redirect immediately.

## Configuration
- `BRANCH_BHT_EN` defined: history table as described.
- Undefined:
  - no table storage; `id_pred_taken` tied 0, so ID redirects never occur;
  - a mispredict is any accepted resolution with `ex_decision = 1`, i.e. static not-taken.
  - Counters and the RECOVER sequence are unchanged.

## Structure
- Package `riscv_branch_pkg`:
  - state enum (RUN, RECOVER);
  - 2-bit counter localparams (SNT=0, WNT=1, WT=2, ST=3), with the reset encoding WNT;
  - the `+4` PC increment constant.
- Sub-module `branch_bht`: counter array with read port (ID index) and update port (EX index, taken, enable), async-reset. It is instantiated only under `BRANCH_BHT_EN`.

## Test plan
- Reset, then a not-taken BEQ at pc 0x40 → `id_pred_taken=0`, no redirect, `br_count=1`, `mispred_count=0`.
- Taken branch at pc 0x40, target 0x80, predicted 0 → cycle after EX: `pc_redirect=1`, target 0x80, three flushes for one cycle; `mispred_count=1`.
- Two taken resolutions at 0x40, then in ID with target 0x80 → `id_pred_taken=1`, same-cycle redirect to 0x80, `flush_if_id` only.
- Predicted-taken branch at 0x100 resolves not-taken → redirect to 0x104 next cycle. A second branch in EX during RECOVER: no count, no table change.
- `stall=1` with a valid mispredicting branch in EX → no redirect, no count. After `stall` drops, the redirect occurs one cycle later.
- `rst_n` asserted during RECOVER → outputs 0 immediately, counters 0, table back to WNT.

Source files
------------

// File: rtl/riscv_branch_pkg.sv
// riscv_branch_pkg: shared FSM states, 2-bit counter encodings and PC step for branch control
package riscv_branch_pkg;
  typedef enum logic {RUN, RECOVER} state_t;
  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT = 2'd2;
  localparam logic [1:0] ST = 2'd3;
  localparam logic [1:0] CTR_RESET = WNT;
  localparam int PC_INC = 4;
  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    return taken ? (c == ST ? ST : c + 2'd1) : (c == SNT ? SNT : c - 2'd1);
  endfunction
endpackage

// File: rtl/branch_bht.sv
// branch_bht: 2-bit saturating-counter history table, combinational read and clocked update
module branch_bht
  import riscv_branch_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_pred,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);
  logic [1:0] ctr [ENTRIES];
  assign rd_pred = ctr[rd_idx][1];
  // counters reset to weakly not-taken; a same-cycle read sees the pre-update value
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_RESET;
    else if (upd_en) ctr[upd_idx] <= ctr_next(ctr[upd_idx], upd_taken);
endmodule

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: branch prediction, mispredict recovery and counters; BRANCH_BHT_EN enables the history table
module branch_redirect_ctrl
  import riscv_branch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BHT_ENTRIES = 16,
  parameter int IDX_W = $clog2(BHT_ENTRIES)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            id_valid,
  input  logic            id_is_branch,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_target,
  output logic            id_pred_taken,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_decision,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  output logic            pc_redirect,
  output logic [XLEN-1:0] pc_redirect_target,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            flush_ex_mem,
  output logic [31:0]     br_count,
  output logic [31:0]     mispred_count
);
  state_t state, state_nx;
  logic [XLEN-1:0] fix_pc;
  logic accept, mispred, rec, id_redir, bht_pred, unused_ok;
  assign accept = ex_valid & ex_is_branch & !stall & (state == RUN);
`ifdef BRANCH_BHT_EN
  branch_bht #(.ENTRIES(BHT_ENTRIES), .IDX_W(IDX_W)) u_bht (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (id_pc[IDX_W+1:2]),
    .rd_pred   (bht_pred),
    .upd_en    (accept),
    .upd_idx   (ex_pc[IDX_W+1:2]),
    .upd_taken (ex_decision)
  );
  assign mispred = accept & (ex_decision != ex_pred_taken);
`else
  assign bht_pred = 1'b0;
  assign mispred = accept & ex_decision;
`endif
  assign unused_ok = ^{id_pc, ex_pc, ex_pred_taken};
  // state, registered recovery PC and performance counters
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      fix_pc <= '0;
      br_count <= '0;
      mispred_count <= '0;
    end else begin
      state <= state_nx;
      if (mispred) fix_pc <= ex_decision ? ex_target : ex_pc + XLEN'(PC_INC);
      br_count <= br_count + 32'(accept);
      mispred_count <= mispred_count + 32'(mispred);
    end
  // next state plus redirect/flush outputs; recovery outranks an ID redirect
  always_comb begin
    state_nx = mispred ? RECOVER : RUN;
    rec = state == RECOVER;
    id_pred_taken = !rec & bht_pred;
    id_redir = !rec & id_valid & id_is_branch & id_pred_taken & !stall;
    pc_redirect = rec | id_redir;
    pc_redirect_target = rec ? fix_pc : id_redir ? id_target : '0;
    flush_if_id = rec | id_redir;
    flush_id_ex = rec;
    flush_ex_mem = rec;
  end
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: directed checks of prediction, recovery, stall and reset behaviour
module tb_branch_redirect_ctrl;
  logic clk = 0, rst_n = 0, stall = 0;
  logic id_valid = 0, id_is_branch = 0, ex_valid = 0, ex_is_branch = 0;
  logic ex_decision = 0, ex_pred_taken = 0;
  logic [31:0] id_pc = 0, id_target = 0, ex_pc = 0, ex_target = 0;
  logic id_pred_taken, pc_redirect, flush_if_id, flush_id_ex, flush_ex_mem;
  logic [31:0] pc_redirect_target, br_count, mispred_count;
  int checks = 0, failures = 0;
  int br_b, m_b;
  always #5 clk = ~clk;
  branch_redirect_ctrl dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .id_valid(id_valid), .id_is_branch(id_is_branch), .id_pc(id_pc), .id_target(id_target),
    .id_pred_taken(id_pred_taken),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_decision(ex_decision),
    .ex_pred_taken(ex_pred_taken), .ex_pc(ex_pc), .ex_target(ex_target),
    .pc_redirect(pc_redirect), .pc_redirect_target(pc_redirect_target),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .br_count(br_count), .mispred_count(mispred_count)
  );
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic step(input logic iv, input logic [31:0] ip, input logic [31:0] it,
                      input logic ev, input logic [31:0] ep, input logic [31:0] et,
                      input logic ed, input logic epr, input logic st);
    @(posedge clk);
    #1;
    id_valid = iv; id_is_branch = iv; id_pc = ip; id_target = it;
    ex_valid = ev; ex_is_branch = ev; ex_pc = ep; ex_target = et;
    ex_decision = ed; ex_pred_taken = epr; stall = st;
    @(negedge clk);
  endtask
  initial begin
    #12;
    check("rst_redir", pc_redirect, 0);
    check("rst_tgt", pc_redirect_target, 0);
    check("rst_flush", {flush_if_id, flush_id_ex, flush_ex_mem}, 0);
    check("rst_br", br_count, 0);
    check("rst_mis", mispred_count, 0);
    check("rst_pred", id_pred_taken, 0);
    #10 rst_n = 1;
    step(1, 'h40, 'h80, 1, 'h40, 'h80, 0, 0, 0);
    check("s1_pred", id_pred_taken, 0);
    check("s1_redir", pc_redirect, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("s2_br", br_count, 1);
    check("s2_mis", mispred_count, 0);
    check("s2_redir", pc_redirect, 0);
    step(0, 0, 0, 1, 'h40, 'h80, 1, 0, 0);
    check("s3_redir", pc_redirect, 0);
    step(1, 'h40, 'h80, 1, 'h40, 'h80, 1, 0, 0);
    check("s4_redir", pc_redirect, 1);
    check("s4_tgt", pc_redirect_target, 'h80);
    check("s4_flush", {flush_if_id, flush_id_ex, flush_ex_mem}, 3'b111);
    check("s4_mis", mispred_count, 1);
    check("s4_br", br_count, 2);
    check("s4_pred", id_pred_taken, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("s5_redir", pc_redirect, 0);
    check("s5_flush", {flush_if_id, flush_id_ex, flush_ex_mem}, 0);
    check("s5_tgt", pc_redirect_target, 0);
    check("s5_br", br_count, 2);
    check("s5_mis", mispred_count, 1);
`ifdef BRANCH_BHT_EN
    step(0, 0, 0, 1, 'h40, 'h80, 1, 1, 0);
    check("b1_redir", pc_redirect, 0);
    step(1, 'h40, 'h80, 0, 0, 0, 0, 0, 0);
    check("b2_pred", id_pred_taken, 1);
    check("b2_redir", pc_redirect, 1);
    check("b2_tgt", pc_redirect_target, 'h80);
    check("b2_flush", {flush_if_id, flush_id_ex, flush_ex_mem}, 3'b100);
    check("b2_br", br_count, 3);
    step(1, 'h40, 'h80, 0, 0, 0, 0, 0, 1);
    check("b3_pred", id_pred_taken, 1);
    check("b3_redir", pc_redirect, 0);
    step(1, 'h40, 'h80, 1, 'h100, 'h180, 0, 1, 0);
    check("b4_pred_old", id_pred_taken, 1);
    check("b4_tgt", pc_redirect_target, 'h80);
    step(1, 'h40, 'h80, 1, 'h40, 'h80, 1, 1, 0);
    check("b5_redir", pc_redirect, 1);
    check("b5_tgt", pc_redirect_target, 'h104);
    check("b5_flush", {flush_if_id, flush_id_ex, flush_ex_mem}, 3'b111);
    check("b5_mis", mispred_count, 2);
    check("b5_br", br_count, 4);
    step(1, 'h40, 'h80, 0, 0, 0, 0, 0, 0);
    check("b6_pred", id_pred_taken, 0);
    check("b6_redir", pc_redirect, 0);
    check("b6_br", br_count, 4);
    check("b6_mis", mispred_count, 2);
    br_b = 4; m_b = 2;
`else
    br_b = 2; m_b = 1;
`endif
    step(0, 0, 0, 1, 'h200, 'h300, 1, 0, 1);
    check("st1_redir", pc_redirect, 0);
    step(0, 0, 0, 1, 'h200, 'h300, 1, 0, 1);
    check("st2_redir", pc_redirect, 0);
    check("st2_br", br_count, br_b);
    check("st2_mis", mispred_count, m_b);
    step(0, 0, 0, 1, 'h200, 'h300, 1, 0, 0);
    check("st3_redir", pc_redirect, 0);
    step(1, 'h40, 'h80, 0, 0, 0, 0, 0, 0);
    check("st4_redir", pc_redirect, 1);
    check("st4_tgt", pc_redirect_target, 'h300);
    check("st4_flush", {flush_if_id, flush_id_ex, flush_ex_mem}, 3'b111);
    check("st4_br", br_count, br_b + 1);
    check("st4_mis", mispred_count, m_b + 1);
    check("st4_pred", id_pred_taken, 0);
    #2 rst_n = 0;
    #1;
    check("rr_redir", pc_redirect, 0);
    check("rr_tgt", pc_redirect_target, 0);
    check("rr_flush", {flush_if_id, flush_id_ex, flush_ex_mem}, 0);
    check("rr_br", br_count, 0);
    check("rr_mis", mispred_count, 0);
    @(negedge clk);
    rst_n = 1;
    step(1, 'h40, 'h80, 0, 0, 0, 0, 0, 0);
    check("rr2_pred", id_pred_taken, 0);
    check("rr2_redir", pc_redirect, 0);
    check("rr2_br", br_count, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
